// File: rtl/median_filter_stream.sv
// Streaming sliding-window median filter with a single-entry output register.
// Optional synchronous flush port is enabled by defining MEDIAN_FILTER_FLUSH_EN.
module median_filter_stream #(
    parameter int DATA_W = 32,
    parameter int WIN    = 5
) (
    input  logic                          clk,
    input  logic                          rst_n,
`ifdef MEDIAN_FILTER_FLUSH_EN
    input  logic                          flush,
`endif
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [DATA_W-1:0]      data_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [DATA_W-1:0]      median,
    output logic [$clog2(WIN+1)-1:0]      fill_cnt
);

    localparam int FW = $clog2(WIN + 1);
    localparam logic [FW-1:0] WIN_CNT = FW'(WIN);
    localparam logic [FW-1:0] WIN_M1  = FW'(WIN - 1);
    localparam logic [FW-1:0] MID     = FW'((WIN - 1) / 2);

    if (WIN < 3 || WIN > 9 || (WIN % 2) == 0) begin : g_bad_win
        $error("median_filter_stream: WIN must be odd and within 3..9");
    end
    if (DATA_W < 8 || DATA_W > 32) begin : g_bad_width
        $error("median_filter_stream: DATA_W must be within 8..32");
    end

    logic                     flush_req;
    logic                     accept;
    logic                     produce;
    logic signed [DATA_W-1:0] win_q  [WIN];
    logic signed [DATA_W-1:0] win_nx [WIN];
    logic signed [DATA_W-1:0] med_nx;
    logic [FW-1:0]            rank;

`ifdef MEDIAN_FILTER_FLUSH_EN
    assign flush_req = flush;
`else
    assign flush_req = 1'b0;
`endif

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !flush_req;
    // A result is due once this accept completes (or keeps) a full window.
    assign produce  = accept && (fill_cnt >= WIN_M1);

    // Window after the shift: index 0 is the oldest sample, WIN-1 the newest.
    // Stable rank = elements strictly smaller, plus equal elements that are older.
    always_comb begin
        // NOTE: combinational logic uses blocking assignments and gives every
        // variable a default first, so no latch can be inferred.
        for (int k = 0; k < WIN - 1; k++) begin
            win_nx[k] = win_q[k + 1];
        end
        win_nx[WIN-1] = data_in;
        med_nx = '0;
        rank   = '0;
        for (int i = 0; i < WIN; i++) begin
            rank = '0;
            for (int j = 0; j < WIN; j++) begin
                if (j != i) begin
                    if ((win_nx[j] < win_nx[i]) || ((win_nx[j] == win_nx[i]) && (j < i))) begin
                        rank = rank + FW'(1);
                    end
                end
            end
            if (rank == MID) begin
                med_nx = win_nx[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the window storage is reset along with the control state so
            // the median path never sees X, even before the first full window.
            for (int k = 0; k < WIN; k++) begin
                win_q[k] <= '0;
            end
            fill_cnt  <= '0;
            out_valid <= 1'b0;
            median    <= '0;
        end else if (flush_req) begin
            fill_cnt  <= '0;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                for (int k = 0; k < WIN; k++) begin
                    win_q[k] <= win_nx[k];
                end
                if (fill_cnt != WIN_CNT) begin
                    fill_cnt <= fill_cnt + FW'(1);
                end
            end
            if (produce) begin
                median    <= med_nx;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_median_filter_stream.sv
// Directed bench for median_filter_stream (DATA_W=32, WIN=5) with hand-computed medians.
// Flush coverage is compiled in when MEDIAN_FILTER_FLUSH_EN is defined.
module tb_median_filter_stream;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic signed [31:0] data_in;
    logic               out_valid;
    logic               out_ready;
    logic signed [31:0] median;
    logic [2:0]         fill_cnt;
`ifdef MEDIAN_FILTER_FLUSH_EN
    logic               flush;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    median_filter_stream #(.DATA_W(32), .WIN(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef MEDIAN_FILTER_FLUSH_EN
        .flush     (flush),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .median    (median),
        .fill_cnt  (fill_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Present one sample at the falling edge, let it be taken on the rising edge,
    // then check the registered outputs just after that edge.
    task automatic send(input string tag, input logic signed [31:0] v, input logic exp_valid,
                        input logic chk_med, input logic signed [31:0] exp_med, input int exp_fill);
        @(negedge clk);
        in_valid = 1'b1;
        data_in  = v;
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check({tag, ".out_valid"}, 32'(out_valid), 32'(exp_valid));
        check({tag, ".fill_cnt"}, 32'(fill_cnt), exp_fill);
        if (chk_med) check({tag, ".median"}, median, exp_med);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        data_in   = '0;
        out_ready = 1'b1;
`ifdef MEDIAN_FILTER_FLUSH_EN
        flush     = 1'b0;
`endif
        #12;
        check("rst.in_ready", 32'(in_ready), 32'd1);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.fill_cnt", 32'(fill_cnt), 32'd0);
        check("rst.median", median, 32'sd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst.in_ready", 32'(in_ready), 32'd1);

        // Warm-up: four accepts give nothing, the fifth gives median 3.
        send("warm0", 5, 1'b0, 1'b0, 0, 1);
        send("warm1", 1, 1'b0, 1'b0, 0, 2);
        send("warm2", 4, 1'b0, 1'b0, 0, 3);
        send("warm3", 2, 1'b0, 1'b0, 0, 4);
        send("warm4", 3, 1'b1, 1'b1, 3, 5);

        // Sliding window with signed samples.
        send("slide0", 100, 1'b1, 1'b1, 3, 5);
        send("slide1", -7, 1'b1, 1'b1, 3, 5);
        send("slide2", -8, 1'b1, 1'b1, 2, 5);

        // Backpressure: result held, no accept; release pops and loads the next result.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        data_in   = 50;
        #1;
        check("bp.in_ready_low", 32'(in_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("bp.out_valid_held", 32'(out_valid), 32'd1);
        check("bp.median_held", median, 32'sd2);
        check("bp.fill_held", 32'(fill_cnt), 32'd5);
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check("bp.in_ready_high", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp.new_valid", 32'(out_valid), 32'd1);
        check("bp.new_median", median, 32'sd3);
        @(posedge clk);
        #1;
        check("bp.popped_valid", 32'(out_valid), 32'd0);
        check("bp.median_kept", median, 32'sd3);
        check("bp.idle_fill", 32'(fill_cnt), 32'd5);

        // Ties, oldest-first ordering: window ends as 7,7,-1,7,-1 then slides in -1.
        send("tie0", 7, 1'b1, 1'b1, 7, 5);
        send("tie1", 7, 1'b1, 1'b1, 7, 5);
        send("tie2", -1, 1'b1, 1'b1, 7, 5);
        send("tie3", 7, 1'b1, 1'b1, 7, 5);
        send("tie4", -1, 1'b1, 1'b1, 7, 5);
        send("tie5", -1, 1'b1, 1'b1, -1, 5);

        // Reset mid-stream with a result pending.
        #2;
        check("mid.pre_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid.out_valid", 32'(out_valid), 32'd0);
        check("mid.fill_cnt", 32'(fill_cnt), 32'd0);
        check("mid.median", median, 32'sd0);
        check("mid.in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        send("nine0", 9, 1'b0, 1'b0, 0, 1);
        send("nine1", 9, 1'b0, 1'b0, 0, 2);
        send("nine2", 9, 1'b0, 1'b0, 0, 3);
        send("nine3", 9, 1'b0, 1'b0, 0, 4);
        send("nine4", 9, 1'b1, 1'b1, 9, 5);

`ifdef MEDIAN_FILTER_FLUSH_EN
        // Flush together with a sample: sample dropped, window emptied.
        @(negedge clk);
        flush    = 1'b1;
        in_valid = 1'b1;
        data_in  = 123;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush.fill_cnt", 32'(fill_cnt), 32'd0);
        check("flush.out_valid", 32'(out_valid), 32'd0);
        send("fl0", 1, 1'b0, 1'b0, 0, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
